// File: rtl/eth_tx_arbiter_if.sv
// eth_tx_arbiter_if
// Groups the request side (three reply sources with their destination MACs)
// and the frame-builder handshake of the transmit arbiter.
//   master : the packet receiver and frame builder. Drives requests, MACs and tx_done.
//   slave  : the arbiter. Drives tx_start, tx_sel, tx_mac and tx_abort.
interface eth_tx_arbiter_if;
    logic        req_arp;
    logic        req_icmp;
    logic        req_udp;
    logic [47:0] arp_mac;
    logic [47:0] icmp_mac;
    logic [47:0] udp_mac;
    logic        tx_done;
    logic        tx_start;
    logic [1:0]  tx_sel;
    logic [47:0] tx_mac;
    logic        tx_abort;

    modport master (
        output req_arp, req_icmp, req_udp,
        output arp_mac, icmp_mac, udp_mac,
        output tx_done,
        input  tx_start, tx_sel, tx_mac, tx_abort
    );

    modport slave (
        input  req_arp, req_icmp, req_udp,
        input  arp_mac, icmp_mac, udp_mac,
        input  tx_done,
        output tx_start, tx_sel, tx_mac, tx_abort
    );
endinterface

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter
// Shares the single MAC transmit path between ARP replies, ICMP echo replies
// and UDP datagrams. Each request is latched with its destination MAC. One
// request is granted at a time and the frame builder is sequenced with a
// start/done handshake. An inter-frame gap follows every grant, and a hung
// builder is aborted by a timeout.
//
// Ports
//   clk         rising-edge system clock
//   rst         synchronous active-high reset
//   bus         request/handshake bundle (slave modport)
//   busy        high whenever the FSM is not IDLE
//   pend        pending flags {udp, icmp, arp}
//   drop_cnt    saturating count of requests dropped while already pending
//   timeout_cnt saturating count of builder aborts
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | arbitrate among pending requests
// START      | tx_start pulse to the builder; load the timeout timer
// WAIT_DONE  | hold tx_sel/tx_mac; wait for tx_done or the timeout
// GAP        | inter-frame gap of IFG_CYCLES cycles; requests still latch
module eth_tx_arbiter #(
    parameter int IFG_CYCLES   = 12,
    parameter int TIMEOUT      = 4096,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    eth_tx_arbiter_if.slave      bus,
    output logic                 busy,
    output logic [2:0]           pend,
    output logic [15:0]          drop_cnt,
    output logic [7:0]           timeout_cnt
);

    // A single down-counter serves both the timeout and the gap. It must be
    // wide enough for whichever load value is larger.
    localparam int TMAX = (TIMEOUT - 2 > IFG_CYCLES - 1) ? TIMEOUT - 2 : IFG_CYCLES - 1;
    localparam int TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);
    localparam int SW   = $clog2(STARVE_LIMIT + 2);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_DONE, S_GAP} state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [SW-1:0] starve_cnt;
    logic [47:0]   arp_mac_q;
    logic [47:0]   icmp_mac_q;
    logic [47:0]   udp_mac_q;

    logic [2:0]    req;
    logic [2:0]    grant;
    logic [2:0]    drops;
    logic [2:0]    store;
    logic [1:0]    drop_inc;
    logic [16:0]   drop_sum;
    logic [1:0]    grant_sel;
    logic [47:0]   grant_mac;

    assign req = {bus.req_udp, bus.req_icmp, bus.req_arp};

    always_comb begin
        grant = 3'b000;
        if (state == S_IDLE) begin
            if (pend[2] && starve_cnt == SW'(STARVE_LIMIT))
                grant = 3'b100;
            else if (pend[0])
                grant = 3'b001;
            else if (pend[1])
                grant = 3'b010;
            else if (pend[2])
                grant = 3'b100;
        end
    end

    // A request to a source that is granted on the same edge is a fresh
    // request rather than a duplicate. The grant takes the old MAC and the
    // new one is stored.
    assign drops     = req & pend & ~grant;
    assign store     = req & ~drops;
    assign drop_inc  = {1'b0, drops[0]} + {1'b0, drops[1]} + {1'b0, drops[2]};
    assign drop_sum  = {1'b0, drop_cnt} + {15'd0, drop_inc};
    assign grant_sel = {grant[2] | grant[1], grant[2] | grant[0]};

    always_comb begin
        grant_mac = 48'd0;
        if (grant[0])
            grant_mac = arp_mac_q;
        else if (grant[1])
            grant_mac = icmp_mac_q;
        else if (grant[2])
            grant_mac = udp_mac_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            timer        <= '0;
            starve_cnt   <= '0;
            arp_mac_q    <= '0;
            icmp_mac_q   <= '0;
            udp_mac_q    <= '0;
            pend         <= 3'b000;
            drop_cnt     <= 16'd0;
            timeout_cnt  <= 8'd0;
            busy         <= 1'b0;
            bus.tx_start <= 1'b0;
            bus.tx_sel   <= 2'b00;
            bus.tx_mac   <= 48'd0;
            bus.tx_abort <= 1'b0;
        end else begin
            pend <= (pend & ~grant) | req;
            if (store[0]) arp_mac_q  <= bus.arp_mac;
            if (store[1]) icmp_mac_q <= bus.icmp_mac;
            if (store[2]) udp_mac_q  <= bus.udp_mac;
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

            if (grant[2] || !pend[2])
                starve_cnt <= '0;
            else if (grant[1] || grant[0])
                starve_cnt <= starve_cnt + 1'b1;

            bus.tx_start <= 1'b0;
            bus.tx_abort <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (grant != 3'b000) begin
                        state        <= S_START;
                        busy         <= 1'b1;
                        bus.tx_start <= 1'b1;
                        bus.tx_sel   <= grant_sel;
                        bus.tx_mac   <= grant_mac;
                    end
                end
                S_START: begin
                    state <= S_WAIT_DONE;
                    // The abort edge is the one on which the timer would
                    // reach TIMEOUT-1, so load TIMEOUT-2 and count down to 0.
                    timer <= TW'(TIMEOUT - 2);
                end
                S_WAIT_DONE: begin
                    if (bus.tx_done) begin
                        state      <= S_GAP;
                        bus.tx_sel <= 2'b00;
                        timer      <= TW'(IFG_CYCLES - 1);
                    end else if (timer == '0) begin
                        state        <= S_GAP;
                        bus.tx_sel   <= 2'b00;
                        bus.tx_abort <= 1'b1;
                        timer        <= TW'(IFG_CYCLES - 1);
                        if (timeout_cnt != 8'hFF)
                            timeout_cnt <= timeout_cnt + 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_GAP: begin
                    if (timer == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
